// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline.
// Fetch FSM states, IF/ID bundle, NOP encoding, field positions.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB   = 0;
  localparam int OP_W     = 7;
  localparam int F3_LSB   = 12;
  localparam int F3_W     = 3;
  localparam int F7B5_BIT = 30;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/riscv_fetch_ifid.sv
// IF/ID pipeline register.
// Flush beats stall beats load; anything else becomes a bubble.
module riscv_fetch_ifid (
  input  logic        iclk,
  input  logic        irst,
  input  logic        iflush,
  input  logic        istall,
  input  logic        iload,
  input  logic [31:0] iinstr,
  input  logic [31:0] ipc,
  input  logic [31:0] ipc_plus4,
  output logic [31:0] oinstr,
  output logic [31:0] opc,
  output logic [31:0] opc_plus4,
  output logic        ovalid
);
  import riscv_pkg::*;

  if_id_t q;

  // A bubble keeps the old PC fields so Decode sees stable values.
  always_ff @(posedge iclk) begin
    if (irst) begin
      q <= '{instr: NOP_INSTR, pc: '0,
             pc_plus4: '0, valid: 1'b0};
    end else if (iflush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (istall) begin
      q <= q;
    end else if (iload) begin
      q <= '{instr: iinstr, pc: ipc,
             pc_plus4: ipc_plus4, valid: 1'b1};
    end else begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end
  end

  assign oinstr    = q.instr;
  assign opc       = q.pc;
  assign opc_plus4 = q.pc_plus4;
  assign ovalid    = q.valid;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: PC, imem requests, wait-state
// timeout and redirect handling in front of the IF/ID register.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istall_f,
  input  logic        istall_d,
  input  logic        iflush_d,
  input  logic        ipc_src_e,
  input  logic [31:0] ipc_target_e,
  output logic        oimem_req,
  output logic [31:0] oimem_addr,
  input  logic        iimem_rdy,
  input  logic [31:0] iimem_rdata,
  output logic [31:0] oinstr_d,
  output logic [31:0] opc_d,
  output logic [31:0] opc_plus4_d,
  output logic        ovalid_d,
  output logic [6:0]  oop_d,
  output logic [2:0]  ofunct3_d,
  output logic        ofunct7b5_d,
  output logic        ofetch_err
);
  import riscv_pkg::*;

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic [CW-1:0] wait_q;
  logic         err_q;
  logic         fetch_done;
  logic         wait_inc;

  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_done = oimem_req && iimem_rdy;
  assign wait_inc   = oimem_req && !iimem_rdy && !ipc_src_e;

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (irst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // One quiet BOOT cycle, then request every cycle.
  always_comb begin
    state_d   = state_q;
    oimem_req = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  oimem_req = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  // Redirect beats stall beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (ipc_src_e)       pc_d = ipc_target_e;
    else if (istall_f)   pc_d = pc_q;
    else if (fetch_done) pc_d = pc_plus4;
  end

  // PC register.
  always_ff @(posedge iclk) begin
    if (irst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  // Saturating run length of unanswered requests.
  always_ff @(posedge iclk) begin
    if (irst)
      wait_q <= '0;
    else if (ipc_src_e || fetch_done)
      wait_q <= '0;
    else if (wait_inc && wait_q != LIM)
      wait_q <= wait_q + 1'b1;
  end

  // Sticky timeout; raised on the wait that reaches the limit.
  always_ff @(posedge iclk) begin
    if (irst)
      err_q <= 1'b0;
    else if (wait_inc && wait_q == LIM_M1)
      err_q <= 1'b1;
  end

  riscv_fetch_ifid u_ifid (
    .iclk      (iclk),
    .irst      (irst),
    .iflush    (iflush_d),
    .istall    (istall_d),
    .iload     (fetch_done && !ipc_src_e),
    .iinstr    (iimem_rdata),
    .ipc       (pc_q),
    .ipc_plus4 (pc_plus4),
    .oinstr    (oinstr_d),
    .opc       (opc_d),
    .opc_plus4 (opc_plus4_d),
    .ovalid    (ovalid_d)
  );

  assign oimem_addr  = pc_q;
  assign ofetch_err  = err_q;
  assign oop_d       = oinstr_d[OP_LSB +: OP_W];
  assign ofunct3_d   = oinstr_d[F3_LSB +: F3_W];
  assign ofunct7b5_d = oinstr_d[F7B5_BIT];

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboard bench for riscv_fetch.
// Driver models fetch rules per cycle; monitor checks Decode outputs.
module tb_riscv_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          WLIM   = 16;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        istall_f = 1'b0;
  logic        istall_d = 1'b0;
  logic        iflush_d = 1'b0;
  logic        ipc_src_e = 1'b0;
  logic [31:0] ipc_target_e = '0;
  logic        oimem_req;
  logic [31:0] oimem_addr;
  logic        iimem_rdy = 1'b0;
  logic [31:0] iimem_rdata;
  logic [31:0] oinstr_d, opc_d, opc_plus4_d;
  logic        ovalid_d;
  logic [6:0]  oop_d;
  logic [2:0]  ofunct3_d;
  logic        ofunct7b5_d;
  logic        ofetch_err;

  always #5 iclk = ~iclk;

  assign iimem_rdata = oimem_addr ^ KEY;

  riscv_fetch #(.RESET_PC(RST_PC), .WAIT_LIMIT(WLIM)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .istall_f    (istall_f),
    .istall_d    (istall_d),
    .iflush_d    (iflush_d),
    .ipc_src_e   (ipc_src_e),
    .ipc_target_e(ipc_target_e),
    .oimem_req   (oimem_req),
    .oimem_addr  (oimem_addr),
    .iimem_rdy   (iimem_rdy),
    .iimem_rdata (iimem_rdata),
    .oinstr_d    (oinstr_d),
    .opc_d       (opc_d),
    .opc_plus4_d (opc_plus4_d),
    .ovalid_d    (ovalid_d),
    .oop_d       (oop_d),
    .ofunct3_d   (ofunct3_d),
    .ofunct7b5_d (ofunct7b5_d),
    .ofetch_err  (ofetch_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] m_pc, m_instr, m_dpc, m_dpc4;
  logic        m_valid, m_err, m_boot;
  int          m_run;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.instr = m_instr;
    e.pc    = m_dpc;
    e.pc4   = m_dpc4;
    e.valid = m_valid;
    e.err   = m_err;
    return e;
  endfunction

  // Monitor: compare Decode-side outputs after every edge.
  always @(posedge iclk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      logic [31:0] w;
      e = exp_q.pop_front();
      w = e.instr;
      chk("instr_d", oinstr_d, e.instr);
      chk("pc_d", opc_d, e.pc);
      chk("pc4_d", opc_plus4_d, e.pc4);
      chk("valid_d", {31'd0, ovalid_d}, {31'd0, e.valid});
      chk("err", {31'd0, ofetch_err}, {31'd0, e.err});
      chk("op_d", {25'd0, oop_d}, {25'd0, w[6:0]});
      chk("f3_d", {29'd0, ofunct3_d}, {29'd0, w[14:12]});
      chk("f7b5", {31'd0, ofunct7b5_d}, {31'd0, w[30]});
    end
  end

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge iclk);
      irst = 1'b1;
      istall_f = 1'b0;
      istall_d = 1'b0;
      iflush_d = 1'b0;
      ipc_src_e = 1'b0;
      iimem_rdy = 1'b0;
      m_pc = RST_PC;
      m_instr = NOP;
      m_dpc = '0;
      m_dpc4 = '0;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_boot = 1'b1;
      m_run = 0;
      exp_q.push_back(snap());
    end
  endtask

  task automatic step(input logic src,
                      input logic [31:0] tgt,
                      input logic sf,
                      input logic sd,
                      input logic fl,
                      input logic rdy);
    logic req, done;
    @(negedge iclk);
    irst = 1'b0;
    ipc_src_e = src;
    ipc_target_e = tgt;
    istall_f = sf;
    istall_d = sd;
    iflush_d = fl;
    iimem_rdy = rdy;
    #1;
    req = !m_boot;
    done = req && rdy;
    chk("req", {31'd0, oimem_req}, {31'd0, req});
    chk("addr", oimem_addr, m_pc);
    if (fl) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (sd) begin
      m_valid = m_valid;
    end else if (done && !src) begin
      m_instr = m_pc ^ KEY;
      m_dpc = m_pc;
      m_dpc4 = m_pc + 32'd4;
      m_valid = 1'b1;
    end else begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
    if (src || done) m_run = 0;
    else if (req && !rdy) m_run++;
    if (m_run >= WLIM) m_err = 1'b1;
    if (src) m_pc = tgt;
    else if (sf) m_pc = m_pc;
    else if (done) m_pc = m_pc + 32'd4;
    m_boot = 1'b0;
    exp_q.push_back(snap());
  endtask

  task automatic go(input int n);
    repeat (n) step(0, '0, 0, 0, 0, 1);
  endtask

  task automatic run_to(input logic [31:0] a);
    for (int i = 0; i < 64 && m_pc != a; i++)
      step(0, '0, 0, 0, 0, 1);
  endtask

  task automatic stall_rdy(input int n, input logic r);
    repeat (n) step(0, '0, 0, 0, 0, r);
  endtask

  initial begin
    do_reset(2);
    go(4);
    run_to(32'h10);
    stall_rdy(3, 1'b0);
    run_to(32'h20);
    repeat (2) step(0, '0, 1, 1, 0, 1);
    run_to(32'h40);
    step(1, 32'h200, 0, 0, 1, 1);
    go(4);
    step(1, 32'h300, 1, 0, 1, 0);
    go(2);
    step(1, 32'hFFFF_FFF4, 0, 0, 1, 1);
    go(5);
    do_reset(1);
    step(1, 32'h80, 0, 0, 0, 1);
    go(3);
    stall_rdy(20, 1'b0);
    go(4);
    stall_rdy(3, 1'b0);
    do_reset(1);
    go(3);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom();
      t[1:0] = 2'b00;
      step($urandom_range(0, 9) == 0, t,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
    end
    @(negedge iclk);
    @(negedge iclk);
    chk("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core. It holds the PC, issues requests to instruction memory and tolerates wait states. It applies redirects from the Execute-stage branch/jump decision and honours stall/flush commands from the hazard unit. Its Decode-stage outputs (opcode, funct3, funct7 bit 5) feed the control unit, and its PC values feed the datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- WAIT_LIMIT, 16: consecutive not-ready cycles after which the sticky fetch-timeout error is raised.

Ports:
- iclk  in  1  clock; reset irst, synchronous, active-high; clock iclk.
- irst  in  1  synchronous active-high reset.
- istall_f  in  1  hold PC (hazard unit).
- istall_d  in  1  hold IF/ID register.
- iflush_d  in  1  replace IF/ID contents with a bubble.
- ipc_src_e  in  1  redirect taken (from control jump decoder).
- ipc_target_e  in  32  redirect target address.
- oimem_req  out  1  fetch request.
- oimem_addr  out  32  fetch address, always equal to PC.
- iimem_rdy  in  1  instruction valid this cycle (combinational memory response allowed).
- iimem_rdata  in  32  instruction word.
- oinstr_d  out  32  Decode-stage instruction.
- opc_d  out  32  Decode-stage PC.
- opc_plus4_d  out  32  Decode-stage PC+4.
- ovalid_d  out  1  Decode slot holds a real instruction.
- oop_d  out  7  oinstr_d[6:0].
- ofunct3_d  out  3  oinstr_d[14:12].
- ofunct7b5_d  out  1  oinstr_d[30].
- ofetch_err  out  1  sticky timeout flag.

## Operation
- FSM: BOOT, then RUN. BOOT is entered on reset and lasts exactly one cycle, with oimem_req=0. After that the FSM stays in RUN.
- In RUN, oimem_req=1 every cycle, including during istall_f. A fetch completes in a cycle where oimem_req && iimem_rdy.
- PC next-state, highest priority first:
  - ipc_src_e: load ipc_target_e. This applies even in BOOT, during a stall, or while waiting, and the pending fetch is abandoned.
  - istall_f: hold.
  - fetch complete: PC+4, with 32-bit wrap-around (32'hFFFF_FFFC becomes 0).
  - otherwise: hold.
- IF/ID next-state, highest priority first:
  - iflush_d: bubble.
  - istall_d: hold all fields.
  - fetch complete and !ipc_src_e: load instr, PC, and PC+4, with ovalid_d=1.
  - otherwise: bubble.
- Bubble: oinstr_d=32'h0000_0013 (addi x0,x0,0), ovalid_d=0, opc_d and opc_plus4_d unchanged.
- Wait counter: counts consecutive RUN cycles with oimem_req && !iimem_rdy. It clears on a completed fetch, on a redirect, or on reset. ofetch_err is set when the counter reaches WAIT_LIMIT and stays set until reset. It does not affect fetching.
- oop_d, ofunct3_d and ofunct7b5_d are purely combinational slices of oinstr_d.

## Timing
- Reset values: PC=RESET_PC, oimem_req=0, oinstr_d=32'h13, opc_d=0, opc_plus4_d=0, ovalid_d=0, ofetch_err=0, counter=0, FSM=BOOT.
- First request is in the cycle after reset deasserts, with oimem_addr=RESET_PC.
- Latency: an instruction accepted in cycle N appears on oinstr_d in cycle N+1.
- Zero-wait memory gives one instruction per cycle.
- Redirect in cycle N: oimem_addr=target in N+1. Whatever memory returns in N is dropped and the slot becomes a bubble. The hazard unit is responsible for asserting iflush_d in the same cycle.
- If istall_f and istall_d are both asserted while iimem_rdy=1, the accepted word is not consumed. PC holds and the same address is re-fetched.
- Reset asserted mid-wait returns the block to the reset state on the next edge. No partial state survives.

## Structure
- Shared package riscv_pkg: NOP_INSTR=32'h0000_0013, the fetch FSM state enum (BOOT, RUN), and opcode field position constants.
- One sub-module, riscv_fetch_ifid: the IF/ID register with its flush/stall/load/bubble priority. PC logic, FSM and counter stay in the top level.

## Test plan
- Reset, then zero-wait memory returning addr^32'hA5A5_0000 → oimem_addr sequence 0,4,8,…, with oinstr_d lagging by one cycle and ovalid_d=1 from the third cycle.
- iimem_rdy low for 3 cycles at PC=0x10 → PC held at 0x10, three bubbles (oinstr_d=0x13, ovalid_d=0), then normal flow resumes.
- ipc_src_e=1 with target 0x200 while PC=0x40, plus iflush_d → next oimem_addr=0x200, IF/ID bubble, and the following instruction carries opc_d=0x200.
- istall_f=istall_d=1 for 2 cycles at PC=0x20 → PC stays 0x20, IF/ID holds its instruction and opc_d, and both advance after release.
- Redirect coincident with istall_f=1 → redirect wins and the PC loads the target.
- iimem_rdy held low for WAIT_LIMIT cycles (16) → ofetch_err rises and stays set after ready returns, clearing only on irst.
